// File: rtl/hr_uart_pkg.sv
// rtl/hr_uart_pkg.sv - shared UART definitions: state encodings, divider helpers, error byte
package hr_uart_pkg;

  // One-hot FSM encodings, shared with the future TX block.
  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_START  = 6'b000010,
    ST_DATA   = 6'b000100,
    ST_PARITY = 6'b001000,
    ST_STOP   = 6'b010000,
    ST_DONE   = 6'b100000
  } state_e;

  localparam int CNT_W = 16;

  // Byte presented on a discarded frame: matches no header character or ASCII
  // digit, so the parser never re-latches a stale byte.
  localparam logic [7:0] ERR_BYTE = 8'h00;

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int half_div(input int bdiv);
    return bdiv / 2;
  endfunction

endpackage

// File: rtl/hr_uart_sync.sv
// rtl/hr_uart_sync.sv - two-flop synchronizer with falling-edge detector
// Purpose: bring the asynchronous serial line into the clk domain and flag
//          high-to-low transitions of the synchronized line.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset (all flops reset to 1 = idle line)
//   async_i  in  asynchronous input
//   sync_o   out synchronized level
//   fall_o   out one-cycle pulse on a synchronized falling edge
module hr_uart_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic s1_q, s2_q, hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      hist_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign fall_o = hist_q & ~s2_q;

endmodule

// File: rtl/hr_uart_rx.sv
// rtl/hr_uart_rx.sv - oversampling UART byte receiver for the heart-rate frame parser
// Purpose: receive 8N1 bytes (8E1 when HR_UART_RX_PARITY_EN is defined), LSB first.
//          data_rx is written at the stop-sample edge; rx_int falls one clock later,
//          so the parser's falling-edge latch always sees settled data.
// Parameters: CLK_FREQ (Hz), BAUD (bit/s); BAUD_DIV = CLK_FREQ/BAUD, HALF = BAUD_DIV/2.
// Ports:
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   rx         in  asynchronous serial input, idle high
//   data_rx    out last received byte (8'h00 on a discarded frame)
//   rx_int     out high while a validated frame is in progress
//   frame_err  out one-cycle pulse when a byte is discarded
module hr_uart_rx
  import hr_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_rx,
  output logic       rx_int,
  output logic       frame_err
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int HALF     = half_div(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  logic line, fall;

  hr_uart_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(rx),
    .sync_o (line),
    .fall_o (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             rx_int_q, rx_int_d;
  logic             ferr_q, ferr_d;
  logic             tick, frame_ok;

  // One full bit period has elapsed since the previous sample point.
  assign tick = (cnt_q == CNT_LAST);

`ifdef HR_UART_RX_PARITY_EN
  logic par_q, par_d;
  // Even parity: data bits plus parity bit carry an even number of ones.
  assign frame_ok = line && ((^shreg_q) == par_q);
`else
  assign frame_ok = line;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fall) state_d = ST_START;
      ST_START: if (cnt_q == CNT_MID) state_d = line ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (tick && bit_idx_q == 3'd7) begin
`ifdef HR_UART_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef HR_UART_RX_PARITY_EN
      ST_PARITY: if (tick) state_d = ST_STOP;
`endif
      ST_STOP:  if (tick) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    // Counter restarts on every state entry and wraps after a full bit period.
    if (state_d != state_q || state_q == ST_IDLE || tick) cnt_d = '0;
    else                                                    cnt_d = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    rx_int_d  = rx_int_q;
    ferr_d    = 1'b0;
`ifdef HR_UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_START: begin
        if (cnt_q == CNT_MID && !line) begin
          rx_int_d  = 1'b1;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shreg_d   = {line, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
`ifdef HR_UART_RX_PARITY_EN
      ST_PARITY: if (tick) par_d = line;
`endif
      ST_STOP: begin
        if (tick) begin
          if (frame_ok) begin
            data_d = shreg_q;
          end else begin
            data_d = ERR_BYTE;
            ferr_d = 1'b1;
          end
        end
      end
      ST_DONE: rx_int_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      data_q    <= 8'h00;
      rx_int_q  <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef HR_UART_RX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      rx_int_q  <= rx_int_d;
      ferr_q    <= ferr_d;
`ifdef HR_UART_RX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign data_rx   = data_q;
  assign rx_int    = rx_int_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_hr_uart_rx.sv
// tb/tb_hr_uart_rx.sv - scoreboard bench for hr_uart_rx
module tb_hr_uart_rx;

  localparam int BD   = 16;
  localparam int HALF = 8;
`ifdef HR_UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_rx;
  logic       rx_int;
  logic       frame_err;

  always #5 clk = ~clk;

  hr_uart_rx #(.CLK_FREQ(160), .BAUD(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .data_rx  (data_rx),
    .rx_int   (rx_int),
    .frame_err(frame_err)
  );

  typedef struct {
    logic [7:0] data;
    bit         err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0, start_cyc = 0, n_rise = 0, n_fall = 0, n_sent = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks each completed byte against the scoreboard head.
  logic       prev_int = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         fe_cnt = 0;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_int  <= 1'b0;
      prev_data <= data_rx;
      fe_cnt    <= 0;
    end else begin
      // Pin drops half a clock before the first edge; two synchronizer flops
      // put E after the second edge, and rx_int is visible after edge E+HALF+1.
      if (rx_int && !prev_int) begin
        n_rise <= n_rise + 1;
        chk("rise_latency", cyc - start_cyc, HALF + 3);
      end
      if (frame_err) chk("ferr_data_zero", {24'h0, data_rx}, 32'h0);
      if (!rx_int && prev_int) begin
        n_fall <= n_fall + 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", exp_q.size(), 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data_rx", {24'h0, data_rx}, {24'h0, mon_e.data});
          chk("data_lead", {24'h0, prev_data}, {24'h0, mon_e.data});
          chk("frame_err_pulses", fe_cnt + int'(frame_err), int'(mon_e.err));
        end
        fe_cnt <= 0;
      end else begin
        fe_cnt <= fe_cnt + int'(frame_err);
      end
      prev_int  <= rx_int;
      prev_data <= data_rx;
    end
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BD) @(negedge clk);
  endtask

  // Reference: a byte survives only with a good stop bit (and good parity when
  // enabled); anything else reads back as 8'h00 with one frame_err pulse.
  task automatic send(input logic [7:0] b, input bit bad_stop, input bit bad_par);
    exp_t e;
    e.err  = bad_stop || (PAR && bad_par);
    e.data = e.err ? 8'h00 : b;
    exp_q.push_back(e);
    n_sent++;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR) drive_bit((^b) ^ bad_par);
    drive_bit(!bad_stop);
    if (bad_stop) drive_bit(1'b1);
  endtask

  initial begin
    logic [7:0] bpm [5];
    logic [7:0] d0;
    logic [7:0] b55;
    int         r0;
    int         w;
    bpm = '{8'h42, 8'h50, 8'h4D, 8'h37, 8'h32};

    repeat (3) @(negedge clk);
    chk("reset_data_rx", {24'h0, data_rx}, 32'h0);
    chk("reset_rx_int", {31'h0, rx_int}, 32'h0);
    chk("reset_frame_err", {31'h0, frame_err}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send(8'h42, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(bpm[i], 1'b0, 1'b0);

    // Short low glitch must be rejected at the start-bit midpoint.
    r0 = n_rise;
    d0 = data_rx;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_rise", n_rise, r0);
    chk("glitch_data", {24'h0, data_rx}, {24'h0, d0});

    send(8'h39, 1'b1, 1'b0);
    send(8'h31, 1'b0, 1'b0);

    // Reset during data bit 4 of 0x55.
    b55 = 8'h55;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b55[i]);
    rx = b55[4];
    repeat (5) @(negedge clk);
    chk("mid_frame_rx_int", {31'h0, rx_int}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data_rx", {24'h0, data_rx}, 32'h0);
    chk("async_rst_rx_int", {31'h0, rx_int}, 32'h0);
    chk("async_rst_frame_err", {31'h0, frame_err}, 32'h0);
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send(8'h4D, 1'b0, 1'b0);

`ifdef HR_UART_RX_PARITY_EN
    send(8'h37, 1'b0, 1'b0);
    send(8'h37, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 16; i++)
      send(8'($urandom_range(0, 255)), ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));

    w = 0;
    while (exp_q.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("fall_count", n_fall, n_sent);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
